// File: rtl/lattice_scanner_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lattice_scanner_if
//  Purpose  : Bundles the request inputs and the scan/write-back outputs of
//             the lattice raster-scan sequencer.
//  Ports    : start_in, stall_in             - requests into the scanner
//             hor_out, vert_out              - current cell, 9 replicated lanes
//             valid_out                      - a cell is issued this cycle
//             wb_valid_out/wb_hor_out/wb_vert_out - delayed issue for write-back
//             busy_out, frame_done_out, frame_count_out - frame status
//  Modports : master (drives requests), slave (the scanner)
//  Revision : 1.0  initial release
// ============================================================================
interface lattice_scanner_if #(
  parameter int HPIXELS = 320,
  parameter int VPIXELS = 180
) ();
  localparam int HOR_SIZE  = $clog2(HPIXELS);
  localparam int VERT_SIZE = $clog2(VPIXELS);

  logic                           start_in;
  logic                           stall_in;
  logic [8:0][HOR_SIZE-1:0]       hor_out;
  logic [8:0][VERT_SIZE-1:0]      vert_out;
  logic                           valid_out;
  logic                           wb_valid_out;
  logic [HOR_SIZE-1:0]            wb_hor_out;
  logic [VERT_SIZE-1:0]           wb_vert_out;
  logic                           busy_out;
  logic                           frame_done_out;
  logic [15:0]                    frame_count_out;

  modport master (
    output start_in, stall_in,
    input  hor_out, vert_out, valid_out, wb_valid_out, wb_hor_out,
           wb_vert_out, busy_out, frame_done_out, frame_count_out
  );

  modport slave (
    input  start_in, stall_in,
    output hor_out, vert_out, valid_out, wb_valid_out, wb_hor_out,
           wb_vert_out, busy_out, frame_done_out, frame_count_out
  );
endinterface
`default_nettype wire

// File: rtl/lattice_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lattice_scanner
//  Purpose  : Raster-scan sequencer. On start it walks every lattice cell once
//             in row-major order, one cell per un-stalled cycle, replicating
//             the coordinate on 9 direction lanes. Each issue also travels a
//             LATENCY-deep delay line so write-back sees the cell position in
//             step with the downstream neighbour addresses.
//  Ports    : clk_in  - clock, rising edge
//             rst_in  - asynchronous active-low reset
//             bus     - lattice_scanner_if.slave (requests + all outputs)
//  Revision : 1.0  initial release
// ============================================================================
module lattice_scanner #(
  parameter int HPIXELS = 320,
  parameter int VPIXELS = 180,
  parameter int LATENCY = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  lattice_scanner_if.slave  bus
);
  localparam int HOR_SIZE  = $clog2(HPIXELS);
  localparam int VERT_SIZE = $clog2(VPIXELS);
  localparam int DRN_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SCAN  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [HOR_SIZE-1:0]  c_HLAST = HOR_SIZE'(HPIXELS - 1);
  localparam logic [VERT_SIZE-1:0] c_VLAST = VERT_SIZE'(VPIXELS - 1);
  localparam logic [DRN_W-1:0]     c_DLAST = DRN_W'(LATENCY - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [HOR_SIZE-1:0]  r_hor;
  logic [VERT_SIZE-1:0] r_vert;
  logic [DRN_W-1:0]     r_drain;
  logic [15:0]          r_frame_count;

  logic                 w_issue;
  logic                 w_last_cell;
  logic                 w_drain_end;
  logic                 w_valid;
  logic                 w_busy;
  logic                 w_done;

  // Delay line stage i holds what was issued i+1 cycles ago.
  logic                 r_dly_v [LATENCY];
  logic [HOR_SIZE-1:0]  r_dly_h [LATENCY];
  logic [VERT_SIZE-1:0] r_dly_y [LATENCY];

  assign w_issue     = (r_state == c_SCAN) && !bus.stall_in;
  assign w_last_cell = (r_hor == c_HLAST) && (r_vert == c_VLAST);
  assign w_drain_end = (r_state == c_DRAIN) && (r_drain == c_DLAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (bus.start_in)            w_next_state = c_SCAN;
      c_SCAN:  if (w_issue && w_last_cell)  w_next_state = c_DRAIN;
      c_DRAIN: if (w_drain_end)             w_next_state = c_IDLE;
      default:                              w_next_state = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      c_SCAN: begin
        w_valid = !bus.stall_in;
        w_busy  = 1'b1;
      end
      c_DRAIN: begin
        w_busy  = 1'b1;
        w_done  = (r_drain == c_DLAST);
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Scan position. The last cell returns the counters to the origin so IDLE
  // always starts the next frame at (0,0).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_hor  <= '0;
      r_vert <= '0;
    end else if (w_issue) begin
      if (r_hor == c_HLAST) begin
        r_hor <= '0;
        if (r_vert == c_VLAST) begin
          r_vert <= '0;
        end else begin
          r_vert <= r_vert + 1'b1;
        end
      end else begin
        r_hor <= r_hor + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drain counter and completed-frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_drain       <= '0;
      r_frame_count <= '0;
    end else begin
      if (r_state == c_DRAIN && !w_drain_end) begin
        r_drain <= r_drain + 1'b1;
      end else begin
        r_drain <= '0;
      end
      if (w_drain_end) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-back delay line. Shifts every cycle; a stall injects a bubble
  // because w_valid is low while the coordinate is still copied.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_dly_v[i] <= 1'b0;
        r_dly_h[i] <= '0;
        r_dly_y[i] <= '0;
      end
    end else begin
      r_dly_v[0] <= w_valid;
      r_dly_h[0] <= r_hor;
      r_dly_y[0] <= r_vert;
      for (int i = 1; i < LATENCY; i++) begin
        r_dly_v[i] <= r_dly_v[i-1];
        r_dly_h[i] <= r_dly_h[i-1];
        r_dly_y[i] <= r_dly_y[i-1];
      end
    end
  end

  assign bus.hor_out         = {9{r_hor}};
  assign bus.vert_out        = {9{r_vert}};
  assign bus.valid_out       = w_valid;
  assign bus.wb_valid_out    = r_dly_v[LATENCY-1];
  assign bus.wb_hor_out      = r_dly_h[LATENCY-1];
  assign bus.wb_vert_out     = r_dly_y[LATENCY-1];
  assign bus.busy_out        = w_busy;
  assign bus.frame_done_out  = w_done;
  assign bus.frame_count_out = r_frame_count;

endmodule
`default_nettype wire

// File: doc/lattice_scanner.md
Name: lattice_scanner

Overview:
Raster-scan sequencer that sits directly upstream of the neighbour-address stage in the lattice update pipeline. On a start request it walks every lattice cell once per frame in row-major order. It drives the same (hor, vert) coordinate onto all 9 direction lanes, one cell per un-stalled cycle. It also carries each issued coordinate through a LATENCY-deep delay line, so write-back logic receives the cell position in the same cycle that the neighbour addresses emerge downstream.

Parameters:
HPIXELS, 320, lattice width in cells; must be >= 2.
VPIXELS, 180, lattice height in cells; must be >= 2.
LATENCY, 3, downstream address-pipeline depth in cycles; must be >= 1.
Derived: HOR_SIZE = $clog2(HPIXELS), VERT_SIZE = $clog2(VPIXELS).

Ports:
clk_in  input  1  sole clock; all state on rising edge
rst_in  input  1  asynchronous, active-low reset
start_in  input  1  frame start request; honoured only in IDLE
stall_in  input  1  hold scan position this cycle; no issue
hor_out  output  [8:0][HOR_SIZE-1:0]  current column, replicated on all 9 lanes
vert_out  output  [8:0][VERT_SIZE-1:0]  current row, replicated on all 9 lanes
valid_out  output  1  hor_out/vert_out carry a cell issued this cycle
wb_valid_out  output  1  delayed valid_out, aligned with downstream addresses
wb_hor_out  output  HOR_SIZE  delayed column
wb_vert_out  output  VERT_SIZE  delayed row
busy_out  output  1  state != IDLE
frame_done_out  output  1  one-cycle pulse at end of frame
frame_count_out  output  16  completed frames, wraps modulo 2^16

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE; hor/vert counters go to 0.
  - All delay-line stages clear: valid 0, coordinates 0.
  - drain counter and frame_count_out go to 0.
  - All outputs read 0.
  - Reset mid-frame abandons the frame; no frame_done_out pulse is produced.
- State IDLE:
  - valid_out = 0; counters hold at 0.
  - start_in = 1 at a clock edge -> SCAN from the next cycle, with hor = 0 and vert = 0.
- State SCAN:
  - valid_out = !stall_in (combinational).
  - hor_out and vert_out always show the counters, stalled or not.
  - On an un-stalled cycle the counters advance after the issue:
    - hor increments.
    - When hor = HPIXELS-1, hor wraps to 0 and vert increments.
    - When the issued cell is (HPIXELS-1, VPIXELS-1), counters return to 0 and the next state is DRAIN.
  - On a stalled cycle the counters and state hold.
- State DRAIN:
  - valid_out = 0.
  - A drain counter runs for exactly LATENCY cycles.
  - frame_done_out is high in the last DRAIN cycle, which is the same cycle the final cell appears on wb_valid_out.
  - frame_count_out increments at the end of that cycle; the next state is IDLE.
- start_in is ignored in SCAN and DRAIN; requests are not queued.
- Delay line:
  - LATENCY stages of {valid, hor, vert}; it advances every cycle regardless of stall_in.
  - wb_* outputs at cycle t equal {valid_out, hor, vert} as issued at cycle t-LATENCY.
  - During a stall, a bubble (valid 0) enters the line.
- Throughput: HPIXELS*VPIXELS issue cycles plus stall cycles, plus LATENCY drain cycles, per frame.
- Back-to-back frames: start_in may be high in the first IDLE cycle after frame_done_out, giving one dead cycle between frames.
- frame_count_out wraps from 65535 to 0 silently.

Test Plan:
- HPIXELS=4, VPIXELS=3, LATENCY=3; start_in pulse sampled at the end of cycle 0:
  - valid_out high in cycles 1-12, issuing (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2).
  - wb_valid_out high in cycles 4-15.
  - frame_done_out high only in cycle 15; busy_out low from cycle 16; frame_count_out = 1.
- Same setup with stall_in high in cycles 5-6:
  - (0,1) is held on hor_out/vert_out through cycles 5-7 and issued in cycle 7.
  - wb_valid_out is low in cycles 8-9.
  - frame_done_out moves to cycle 17.
- start_in held high continuously:
  - Frames run back-to-back, with frame_done_out at cycles 15, 31, 47.
  - frame_count_out steps 1, 2, 3.
  - The start_in level during SCAN does not restart the scan.
- rst_in driven low asynchronously in cycle 8 (mid-frame), between clock edges:
  - All outputs go to 0 immediately; no frame_done_out pulse.
  - After release, a new start_in produces a full 12-cell frame from (0,0).
- Wrap check with HPIXELS=5, VPIXELS=2:
  - Issue after (4,0) is (0,1).
  - Issue after (4,1) is none; valid_out drops and state is DRAIN.
- frame_count_out preloaded to 65535 via a forced state:
  - One completed frame gives frame_count_out = 0.
